aes_128_keyram_ctrl: RTL and testbench

Controller that sequences the double-buffered AES-128 round-key RAM (`aes_128_keyram_2key_switch`). It streams the 22 expanded 64-bit key words from the key-expansion engine into the shadow buffer and arbitrates block starts from the cipher core. It issues `switch_key` only at block boundaries and paces `key_ready` per round. It sits between the host key interface, the key-expansion engine, the cipher core and the key RAM.

---
 rtl/aes_128_keyram_pkg.sv | 16 +
 rtl/aes_128_keyram_wr_seq.sv | 70 +++++++
 rtl/aes_128_keyram_ctrl.sv | 111 +++++++++++
 tb/tb_aes_128_keyram_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_keyram_pkg.sv
// Shared constants and load-FSM encoding for the AES-128 double-buffered round-key RAM controller.
package aes_128_keyram_pkg;

  localparam int NUM_WORDS  = 22;
  localparam int NUM_ROUNDS = 11;
  localparam int WR_CNT_W   = 5;
  localparam int RND_CNT_W  = 4;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_START = 2'd1,
    L_FILL  = 2'd2,
    L_PEND  = 2'd3
  } load_state_e;

endpackage

// File: rtl/aes_128_keyram_wr_seq.sv
// Load sequencer: starts key expansion, streams expanded words into the shadow buffer, then waits for a switch slot.
module aes_128_keyram_wr_seq
  import aes_128_keyram_pkg::load_state_e, aes_128_keyram_pkg::L_IDLE, aes_128_keyram_pkg::L_START,
         aes_128_keyram_pkg::L_FILL, aes_128_keyram_pkg::L_PEND, aes_128_keyram_pkg::WR_CNT_W;
#(
  parameter int NUM_WORDS = aes_128_keyram_pkg::NUM_WORDS
) (
  input  logic        clk,
  input  logic        kill_n,
  input  logic        key_load_req,
  input  logic        load_ack,
  input  logic        exp_valid,
  input  logic [63:0] exp_data,
  input  logic        switch_fire,
  output logic        exp_start,
  output logic        en_wr,
  output logic [63:0] key_round_wr,
  output logic [1:0]  load_state,
  output logic        busy
);

  load_state_e         state;
  logic [WR_CNT_W-1:0] wr_cnt;
  logic                last_word;

  assign last_word  = (wr_cnt == WR_CNT_W'(NUM_WORDS - 1));
  assign load_state = state;

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state        <= L_IDLE;
      wr_cnt       <= '0;
      exp_start    <= 1'b0;
      en_wr        <= 1'b0;
      key_round_wr <= '0;
      busy         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle with non-blocking assignments; the case only raises them.
      exp_start <= 1'b0;
      en_wr     <= 1'b0;
      case (state)
        L_IDLE: begin
          // The host still holds its request in the ack cycle; that is the finished load, not a new one.
          if (key_load_req && !load_ack) begin
            state     <= L_START;
            exp_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        L_START: state <= L_FILL;
        L_FILL: begin
          if (exp_valid) begin
            en_wr        <= 1'b1;
            key_round_wr <= exp_data;
            wr_cnt       <= last_word ? '0 : wr_cnt + 1'b1;
            if (last_word) state <= L_PEND;
          end
        end
        L_PEND: begin
          if (switch_fire) begin
            state <= L_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_128_keyram_ctrl.sv
// AES-128 key RAM controller: block grant/switch arbitration and round pacing around the load sequencer.
// Define AES_KEYRAM_CTRL_ERR_EN to add the sticky protocol-violation output err[2:0].
module aes_128_keyram_ctrl
  import aes_128_keyram_pkg::L_FILL, aes_128_keyram_pkg::L_PEND, aes_128_keyram_pkg::RND_CNT_W;
#(
  parameter int NUM_WORDS  = aes_128_keyram_pkg::NUM_WORDS,
  parameter int NUM_ROUNDS = aes_128_keyram_pkg::NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        kill_n,
  input  logic        key_load_req,
  output logic        key_load_ack,
  output logic        exp_start,
  input  logic        exp_valid,
  input  logic [63:0] exp_data,
  input  logic        blk_req,
  output logic        blk_gnt,
  input  logic        round_req,
  output logic        en_wr,
  output logic [63:0] key_round_wr,
  output logic        key_ready,
  output logic        switch_key,
  input  logic        key_idx,
  output logic        key_valid,
  output logic        busy
`ifdef AES_KEYRAM_CTRL_ERR_EN
  ,
  output logic [2:0]  err
`endif
);

  logic [1:0]           load_state;
  logic                 load_pend;
  logic                 blk_act;
  logic [RND_CNT_W-1:0] rnd_cnt;
  logic                 switch_slot;
  logic                 grant_ok;
  logic                 round_ok;
  logic                 key_idx_unused;

  // The active buffer index is informational only; swaps are tracked by key_valid.
  assign key_idx_unused = key_idx;

  // A pending switch blocks new grants, so a waiting key always wins the next block boundary.
  assign load_pend   = (load_state == L_PEND);
  assign switch_slot = load_pend && !blk_act && !blk_gnt;
  assign grant_ok    = blk_req && key_valid && !blk_act && !blk_gnt && !load_pend;
  assign round_ok    = round_req && blk_act && (rnd_cnt < RND_CNT_W'(NUM_ROUNDS));

  aes_128_keyram_wr_seq #(
    .NUM_WORDS(NUM_WORDS)
  ) u_wr_seq (
    .clk         (clk),
    .kill_n      (kill_n),
    .key_load_req(key_load_req),
    .load_ack    (key_load_ack),
    .exp_valid   (exp_valid),
    .exp_data    (exp_data),
    .switch_fire (switch_slot),
    .exp_start   (exp_start),
    .en_wr       (en_wr),
    .key_round_wr(key_round_wr),
    .load_state  (load_state),
    .busy        (busy)
  );

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      blk_gnt      <= 1'b0;
      blk_act      <= 1'b0;
      rnd_cnt      <= '0;
      key_ready    <= 1'b0;
      switch_key   <= 1'b0;
      key_load_ack <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      blk_gnt      <= grant_ok;
      key_ready    <= round_ok;
      switch_key   <= switch_slot;
      key_load_ack <= switch_slot;
      if (switch_slot) key_valid <= 1'b1;

      if (grant_ok)      rnd_cnt <= '0;
      else if (round_ok) rnd_cnt <= rnd_cnt + 1'b1;

      // The block ends in the cycle the final key_ready is out, freeing the next cycle for a switch.
      if (blk_gnt)
        blk_act <= 1'b1;
      else if (blk_act && rnd_cnt == RND_CNT_W'(NUM_ROUNDS))
        blk_act <= 1'b0;
    end
  end

`ifdef AES_KEYRAM_CTRL_ERR_EN
  logic load_req_q;

  // A load request counts as a violation only when it newly rises while a load is already running.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      err        <= 3'b000;
      load_req_q <= 1'b0;
    end else begin
      load_req_q <= key_load_req;
      if (round_req && !round_ok)                 err[0] <= 1'b1;
      if (exp_valid && load_state != L_FILL)      err[1] <= 1'b1;
      if (key_load_req && !load_req_q && busy)    err[2] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_128_keyram_ctrl.sv
// Scoreboard bench for aes_128_keyram_ctrl: stimulus pushes timed expectations, a negedge monitor pops and compares.
module tb_aes_128_keyram_ctrl;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        kill_n;
  logic        key_load_req;
  logic        key_load_ack;
  logic        exp_start;
  logic        exp_valid;
  logic [63:0] exp_data;
  logic        blk_req;
  logic        blk_gnt;
  logic        round_req;
  logic        en_wr;
  logic [63:0] key_round_wr;
  logic        key_ready;
  logic        switch_key;
  logic        key_idx;
  logic        key_valid;
  logic        busy;
`ifdef AES_KEYRAM_CTRL_ERR_EN
  logic [2:0]  err;
`endif

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  exp_t q_wr[$];
  exp_t q_start[$];
  exp_t q_rdy[$];
  exp_t q_gnt[$];
  exp_t q_sw[$];

  aes_128_keyram_ctrl dut (
    .clk         (clk),
    .kill_n      (kill_n),
    .key_load_req(key_load_req),
    .key_load_ack(key_load_ack),
    .exp_start   (exp_start),
    .exp_valid   (exp_valid),
    .exp_data    (exp_data),
    .blk_req     (blk_req),
    .blk_gnt     (blk_gnt),
    .round_req   (round_req),
    .en_wr       (en_wr),
    .key_round_wr(key_round_wr),
    .key_ready   (key_ready),
    .switch_key  (switch_key),
    .key_idx     (key_idx),
    .key_valid   (key_valid),
    .busy        (busy)
`ifdef AES_KEYRAM_CTRL_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ev(input int c, input logic [63:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    return e;
  endfunction

  // Pops the oldest expectation when the DUT fires; flags firings nobody expected and expectations whose cycle passed.
  task automatic service(input string nm, input logic fired, input bit has_data,
                         input logic [63:0] data, ref exp_t q[$]);
    exp_t e;
    if (fired) begin
      if (q.size() == 0) begin
        check({nm, " unexpected"}, 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check({nm, " cycle"}, 64'(e.cyc), 64'(cyc));
        if (has_data) check({nm, " data"}, data, e.data);
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check({nm, " missing"}, 64'd0, 64'd1);
      void'(q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (switch_key || key_load_ack) check("ack_with_switch", key_load_ack, switch_key);
    service("en_wr",      en_wr,                       1'b1, key_round_wr,     q_wr);
    service("exp_start",  exp_start,                   1'b1, 64'(busy),        q_start);
    service("key_ready",  key_ready,                   1'b0, 64'd0,            q_rdy);
    service("blk_gnt",    blk_gnt,                     1'b0, 64'd0,            q_gnt);
    service("switch_key", switch_key || key_load_ack,  1'b1, 64'(key_valid),   q_sw);
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream_words(input int t, input logic [63:0] base, input int n);
    for (int w = 0; w < n; w++) begin
      at(t + w);
      exp_valid = 1'b1;
      exp_data  = base + 64'(w);
      q_wr.push_back(ev(cyc + 1, base + 64'(w)));
    end
    at(t + n);
    exp_valid = 1'b0;
  endtask

  task automatic run_rounds(input int t, input int n);
    for (int k = 0; k < n; k++) begin
      at(t + 4 * k);
      round_req = 1'b1;
      if (k < 11) q_rdy.push_back(ev(cyc + 1, 64'd0));
      at(cyc + 1);
      round_req = 1'b0;
    end
  endtask

  task automatic grant(input int t);
    at(t);
    blk_req = 1'b1;
    q_gnt.push_back(ev(t + 1, 64'd0));
    at(t + 2);
    blk_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, t4;
    kill_n = 1'b0; key_load_req = 1'b0; exp_valid = 1'b0; exp_data = '0;
    blk_req = 1'b0; round_req = 1'b0; key_idx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst en_wr", en_wr, 0);
    check("rst exp_start", exp_start, 0);
    check("rst key_ready", key_ready, 0);
    check("rst switch_key", switch_key, 0);
    check("rst key_load_ack", key_load_ack, 0);
    check("rst blk_gnt", blk_gnt, 0);
    check("rst key_valid", key_valid, 0);
    check("rst busy", busy, 0);
    check("rst key_round_wr", key_round_wr, 0);
`ifdef AES_KEYRAM_CTRL_ERR_EN
    check("rst err", err, 0);
`endif
    kill_n = 1'b1;

    // Block request with no key loaded: never granted.
    t0 = cyc + 2;
    at(t0);
    blk_req = 1'b1;
    at(t0 + 5);
    blk_req = 1'b0;
    check("no_key key_valid", key_valid, 0);

    // Stray expansion word while idle, then a full load with a request re-raised mid-fill.
    t0 = t0 + 8;
    at(t0);
    exp_valid = 1'b1;
    exp_data  = 64'hDEAD_BEEF_0000_0001;
    at(t0 + 1);
    exp_valid = 1'b0;
    at(t0 + 2);
    key_load_req = 1'b1;
    q_start.push_back(ev(t0 + 3, 64'd1));
    q_sw.push_back(ev(t0 + 27, 64'd1));
    fork
      stream_words(t0 + 4, 64'h0, 22);
      begin
        at(t0 + 5);
        key_load_req = 1'b0;
        at(t0 + 8);
        key_load_req = 1'b1;
      end
    join
    at(t0 + 28);
    key_load_req = 1'b0;
    check("load1 key_valid", key_valid, 1);
    check("load1 busy", busy, 0);
`ifdef AES_KEYRAM_CTRL_ERR_EN
    check("load1 err", err, 3'b110);
`endif

    // One block: 11 rounds spaced 4 cycles, then a 12th request that must be ignored.
    t1 = t0 + 30;
    grant(t1);
    run_rounds(t1 + 2, 12);
    at(t1 + 48);
    check("block1 key_valid", key_valid, 1);
`ifdef AES_KEYRAM_CTRL_ERR_EN
    check("block1 err", err, 3'b111);
`endif

    // Load completing mid-block: switch waits for block end, a new request is granted only after it.
    t2 = t1 + 50;
    q_sw.push_back(ev(t2 + 45, 64'd1));
    fork
      begin
        grant(t2);
        run_rounds(t2 + 2, 11);
        at(t2 + 44);
        blk_req = 1'b1;
        q_gnt.push_back(ev(t2 + 46, 64'd0));
        at(t2 + 47);
        blk_req = 1'b0;
      end
      begin
        at(t2 + 3);
        key_load_req = 1'b1;
        q_start.push_back(ev(t2 + 4, 64'd1));
        stream_words(t2 + 6, 64'h1111_0000_0000_0000, 22);
        at(t2 + 46);
        key_load_req = 1'b0;
      end
    join
    check("block2 busy", busy, 0);

    // Kill at word 10 of a load: everything clears, no switch, then a clean reload.
    t3 = t2 + 55;
    at(t3);
    key_load_req = 1'b1;
    q_start.push_back(ev(t3 + 1, 64'd1));
    stream_words(t3 + 2, 64'h2222_0000_0000_0000, 10);
    at(t3 + 13);
    exp_valid = 1'b1;
    exp_data  = 64'h2222_0000_0000_000A;
    kill_n    = 1'b0;
    #1;
    check("kill en_wr", en_wr, 0);
    check("kill key_valid", key_valid, 0);
    check("kill busy", busy, 0);
    check("kill key_round_wr", key_round_wr, 0);
    check("kill switch_key", switch_key, 0);
`ifdef AES_KEYRAM_CTRL_ERR_EN
    check("kill err", err, 0);
`endif
    at(t3 + 14);
    exp_valid    = 1'b0;
    key_load_req = 1'b0;
    at(t3 + 16);
    kill_n = 1'b1;
    at(t3 + 18);
    check("post_kill key_valid", key_valid, 0);

    t4 = t3 + 20;
    at(t4);
    key_load_req = 1'b1;
    q_start.push_back(ev(t4 + 1, 64'd1));
    q_sw.push_back(ev(t4 + 25, 64'd1));
    stream_words(t4 + 2, 64'h3333_0000_0000_0000, 22);
    at(t4 + 26);
    key_load_req = 1'b0;
    check("reload key_valid", key_valid, 1);
    grant(t4 + 27);
    at(t4 + 35);
`ifdef AES_KEYRAM_CTRL_ERR_EN
    check("reload err", err, 0);
`endif

    check("leftover en_wr", 64'(q_wr.size()), 0);
    check("leftover exp_start", 64'(q_start.size()), 0);
    check("leftover key_ready", 64'(q_rdy.size()), 0);
    check("leftover blk_gnt", 64'(q_gnt.size()), 0);
    check("leftover switch_key", 64'(q_sw.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
